// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared TLB maintenance types: entry/result layouts, op encodings, controller states.
// Entry layout follows the CSR view: TLBEHI/ASID/PS fields, then the two ELO halves.
package tlb_maint_ctrl_pkg;

  localparam int TLBNUM   = 16;
  localparam int TLBIDLEN = $clog2(TLBNUM);

  typedef enum logic [2:0] {
    OP_SRCH = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } tlb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRCH,
    ST_RD,
    ST_WR,
    ST_INV,
    ST_DONE
  } tlb_state_e;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic                found;
    logic [TLBIDLEN-1:0] index;
  } tlb_result_t;

  // During TLB refill handling the written entry is always made valid.
  function automatic tlb_entry_t wr_entry(input tlb_entry_t ent, input logic refill);
    tlb_entry_t r;
    r = ent;
    if (refill) r.e = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/tlb_fill_idx_gen.sv
// TLBFILL victim index source. TLBFILL_LFSR_EN selects a free-running 16-bit Galois LFSR;
// otherwise a round-robin counter that steps once per accepted FILL.
module tlb_fill_idx_gen
  import tlb_maint_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                adv,
  output logic [TLBIDLEN-1:0] idx
);

`ifdef TLBFILL_LFSR_EN
  logic [15:0] lfsr;
  logic        unused_adv;

  assign unused_adv = adv;
  assign idx        = lfsr[TLBIDLEN-1:0];

  // Right-shifting Galois form of taps 16,14,13,11.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= 16'hACE1;
    else         lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
  end
`else
  logic [TLBIDLEN-1:0] cnt;

  assign idx = cnt;

  // TLBNUM is a power of two, so the natural wrap gives TLBNUM-1 -> 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  cnt <= '0;
    else if (adv) cnt <= cnt + TLBIDLEN'(1);
  end
`endif

endmodule

// File: rtl/tlb_maint_ctrl.sv
// Commit-stage sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB, one op in flight, done at accept+2.
// Build option TLBFILL_LFSR_EN picks the FILL index source (see tlb_fill_idx_gen).
module tlb_maint_ctrl
  import tlb_maint_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [2:0]          op_type,
  input  logic [4:0]          inv_op,
  input  logic [9:0]          inv_asid,
  input  logic [31:0]         inv_va,
  input  tlb_entry_t          csr_entry,
  input  logic [TLBIDLEN-1:0] csr_index,
  input  logic                csr_refill,
  output logic                s_req,
  output logic [18:0]         s_vppn,
  output logic                s_va_bit12,
  output logic [9:0]          s_asid,
  input  tlb_result_t         s_result,
  output logic [TLBIDLEN-1:0] r_index,
  input  tlb_entry_t          r_entry,
  output logic                we,
  output logic [TLBIDLEN-1:0] w_index,
  output tlb_entry_t          w_entry,
  output logic                invtlb_valid,
  output logic [4:0]          invtlb_op,
  output logic [9:0]          invtlb_asid,
  output logic [31:0]         invtlb_va,
  output logic                csr_wb_valid,
  output logic                csr_wb_srch,
  output logic                csr_wb_ne,
  output logic [TLBIDLEN-1:0] csr_wb_index,
  output tlb_entry_t          csr_wb_entry,
  output logic                done,
  output logic                tlb_flush
);

  tlb_state_e          state;
  logic                accept;
  logic                fill_q;
  logic                fill_adv;
  logic [TLBIDLEN-1:0] fill_idx;
  logic [TLBIDLEN-1:0] fill_idx_q;

  assign accept   = op_valid && op_ready;
  assign fill_adv = accept && (op_type == OP_FILL);

  tlb_fill_idx_gen u_fill_idx (
    .clk    (clk),
    .resetn (resetn),
    .adv    (fill_adv),
    .idx    (fill_idx)
  );

  // Keys and write data come live from the CSR file during the execute cycle; idle value is 0.
  assign s_vppn     = s_req ? csr_entry.vppn : '0;
  assign s_asid     = s_req ? csr_entry.asid : '0;
  assign s_va_bit12 = 1'b0;
  assign r_index    = (state == ST_RD) ? csr_index : '0;
  assign w_index    = we ? (fill_q ? fill_idx_q : csr_index) : '0;
  assign w_entry    = we ? wr_entry(csr_entry, csr_refill) : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      op_ready     <= 1'b1;
      s_req        <= 1'b0;
      we           <= 1'b0;
      fill_q       <= 1'b0;
      fill_idx_q   <= '0;
      invtlb_valid <= 1'b0;
      invtlb_op    <= '0;
      invtlb_asid  <= '0;
      invtlb_va    <= '0;
      csr_wb_valid <= 1'b0;
      csr_wb_srch  <= 1'b0;
      csr_wb_ne    <= 1'b0;
      csr_wb_index <= '0;
      csr_wb_entry <= '0;
      done         <= 1'b0;
      tlb_flush    <= 1'b0;
    end else begin
      s_req        <= 1'b0;
      we           <= 1'b0;
      invtlb_valid <= 1'b0;
      csr_wb_valid <= 1'b0;
      done         <= 1'b0;
      tlb_flush    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_ready <= 1'b0;
            case (op_type)
              OP_SRCH: begin
                state <= ST_SRCH;
                s_req <= 1'b1;
              end
              OP_RD: state <= ST_RD;
              OP_WR, OP_FILL: begin
                state      <= ST_WR;
                we         <= 1'b1;
                fill_q     <= (op_type == OP_FILL);
                fill_idx_q <= fill_idx;
              end
              OP_INV: begin
                state        <= ST_INV;
                invtlb_valid <= 1'b1;
                invtlb_op    <= inv_op;
                invtlb_asid  <= inv_asid;
                invtlb_va    <= inv_va;
              end
              default: begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            endcase
          end
        end
        ST_SRCH: begin
          state        <= ST_DONE;
          done         <= 1'b1;
          csr_wb_valid <= 1'b1;
          csr_wb_srch  <= 1'b1;
          csr_wb_ne    <= ~s_result.found;
          csr_wb_index <= s_result.found ? s_result.index : csr_index;
          csr_wb_entry <= '0;
        end
        ST_RD: begin
          state        <= ST_DONE;
          done         <= 1'b1;
          csr_wb_valid <= 1'b1;
          csr_wb_srch  <= 1'b0;
          csr_wb_ne    <= ~r_entry.e;
          csr_wb_index <= csr_index;
          csr_wb_entry <= r_entry.e ? r_entry : '0;
        end
        ST_WR, ST_INV: begin
          state     <= ST_DONE;
          done      <= 1'b1;
          tlb_flush <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed bench for tlb_maint_ctrl: a behavioural TLB answers search/read/write/invtlb,
// a vector table drives single ops, and hand sequences cover back-to-back and reset abort.
module tb_tlb_maint_ctrl;
  import tlb_maint_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                resetn;
  logic                op_valid, op_ready;
  logic [2:0]          op_type;
  logic [4:0]          inv_op;
  logic [9:0]          inv_asid;
  logic [31:0]         inv_va;
  tlb_entry_t          csr_entry;
  logic [TLBIDLEN-1:0] csr_index;
  logic                csr_refill;
  logic                s_req, s_va_bit12;
  logic [18:0]         s_vppn;
  logic [9:0]          s_asid;
  tlb_result_t         s_result;
  logic [TLBIDLEN-1:0] r_index;
  tlb_entry_t          r_entry;
  logic                we;
  logic [TLBIDLEN-1:0] w_index;
  tlb_entry_t          w_entry;
  logic                invtlb_valid;
  logic [4:0]          invtlb_op;
  logic [9:0]          invtlb_asid;
  logic [31:0]         invtlb_va;
  logic                csr_wb_valid, csr_wb_srch, csr_wb_ne;
  logic [TLBIDLEN-1:0] csr_wb_index;
  tlb_entry_t          csr_wb_entry;
  logic                done, tlb_flush;

  always #5 clk = ~clk;

  tlb_maint_ctrl dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va), .csr_entry(csr_entry),
    .csr_index(csr_index), .csr_refill(csr_refill), .s_req(s_req), .s_vppn(s_vppn),
    .s_va_bit12(s_va_bit12), .s_asid(s_asid), .s_result(s_result), .r_index(r_index),
    .r_entry(r_entry), .we(we), .w_index(w_index), .w_entry(w_entry),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
    .invtlb_va(invtlb_va), .csr_wb_valid(csr_wb_valid), .csr_wb_srch(csr_wb_srch),
    .csr_wb_ne(csr_wb_ne), .csr_wb_index(csr_wb_index), .csr_wb_entry(csr_wb_entry),
    .done(done), .tlb_flush(tlb_flush)
  );

  // Behavioural TLB
  tlb_entry_t          tlb [TLBNUM];
  logic                pl_clr, pl_we;
  logic [TLBIDLEN-1:0] pl_idx;
  tlb_entry_t          pl_ent;

  always @(posedge clk) begin
    if (pl_clr) begin
      for (int i = 0; i < TLBNUM; i++) tlb[i] <= '0;
    end else if (pl_we) tlb[pl_idx] <= pl_ent;
    else if (we) tlb[w_index] <= w_entry;
    if (invtlb_valid && invtlb_op == 5'd5)
      for (int i = 0; i < TLBNUM; i++)
        if (!tlb[i].g && tlb[i].asid == invtlb_asid && tlb[i].vppn == invtlb_va[31:13])
          tlb[i].e <= 1'b0;
  end

  always_comb begin
    s_result = '0;
    for (int i = 0; i < TLBNUM; i++)
      if (tlb[i].e && tlb[i].vppn == s_vppn && (tlb[i].g || tlb[i].asid == s_asid)) begin
        s_result.found = 1'b1;
        s_result.index = TLBIDLEN'(i);
      end
  end

  assign r_entry = tlb[r_index];

  // Strobe monitor
  int                  n_we, n_inv, n_wb, n_done, n_sreq;
  logic                flush_at_done, wb_srch_s, wb_ne_s;
  logic [TLBIDLEN-1:0] w_idx_s, wb_idx_s;
  tlb_entry_t          w_ent_s, wb_ent_s;
  logic [46:0]         inv_s;

  initial begin
    n_we = 0; n_inv = 0; n_wb = 0; n_done = 0; n_sreq = 0;
  end

  always @(negedge clk) begin
    if (s_req) n_sreq++;
    if (we) begin n_we++; w_idx_s = w_index; w_ent_s = w_entry; end
    if (invtlb_valid) begin n_inv++; inv_s = {invtlb_op, invtlb_asid, invtlb_va}; end
    if (csr_wb_valid) begin
      n_wb++; wb_srch_s = csr_wb_srch; wb_ne_s = csr_wb_ne;
      wb_idx_s = csr_wb_index; wb_ent_s = csr_wb_entry;
    end
    if (done) begin n_done++; flush_at_done = tlb_flush; end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]          op;
    tlb_entry_t          ent;
    logic [TLBIDLEN-1:0] idx;
    logic                refill;
    logic [4:0]          iop;
    logic [9:0]          iasid;
    logic [31:0]         iva;
    int                  lat;
    int                  e_sreq, e_we, e_inv, e_wb;
    logic                e_flush, e_srch, e_ne;
    logic [TLBIDLEN-1:0] e_idx;
    tlb_entry_t          e_ent;
  } vec_t;

  // Called just after a negedge; returns one negedge (+1) after the done cycle.
  task automatic run_vec(input vec_t v, input string nm);
    int n, lat, b_we, b_inv, b_wb, b_done, b_sreq;
    csr_entry = v.ent; csr_index = v.idx; csr_refill = v.refill;
    inv_op = v.iop; inv_asid = v.iasid; inv_va = v.iva; op_type = v.op;
    b_we = n_we; b_inv = n_inv; b_wb = n_wb; b_done = n_done; b_sreq = n_sreq;
    op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    op_valid = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin @(negedge clk); lat++; end
    @(negedge clk); #1;
    chk({nm, ".latency"}, lat, v.lat);
    chk({nm, ".done_cnt"}, n_done - b_done, 1);
    chk({nm, ".sreq_cnt"}, n_sreq - b_sreq, v.e_sreq);
    chk({nm, ".we_cnt"}, n_we - b_we, v.e_we);
    chk({nm, ".inv_cnt"}, n_inv - b_inv, v.e_inv);
    chk({nm, ".wb_cnt"}, n_wb - b_wb, v.e_wb);
    chk({nm, ".flush"}, flush_at_done, v.e_flush);
    if (v.e_wb == 1) begin
      chk({nm, ".wb_srch"}, wb_srch_s, v.e_srch);
      chk({nm, ".wb_ne"}, wb_ne_s, v.e_ne);
      chk({nm, ".wb_index"}, wb_idx_s, v.e_idx);
      if (!v.e_srch) chk({nm, ".wb_entry"}, wb_ent_s, v.e_ent);
    end
    if (v.e_we == 1) begin
      chk({nm, ".w_index"}, w_idx_s, v.e_idx);
      chk({nm, ".w_entry"}, w_ent_s, v.e_ent);
    end
    if (v.e_inv == 1) chk({nm, ".inv_operands"}, inv_s, {v.iop, v.iasid, v.iva});
  endtask

  localparam int NV = 9;
  vec_t       vecs [NV];
  string      vname [NV];
  tlb_entry_t e5, e7z, e7r, ew, key;
  vec_t       fv;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; op_valid = 1'b0; op_type = '0; inv_op = '0; inv_asid = '0; inv_va = '0;
    csr_entry = '0; csr_index = '0; csr_refill = 1'b0;
    pl_clr = 1'b1; pl_we = 1'b0; pl_idx = '0; pl_ent = '0;

    e5 = '0;  e5.vppn = 19'h12345; e5.asid = 10'd3; e5.e = 1'b1; e5.ps = 6'd12; e5.ppn0 = 20'h00ABC; e5.v0 = 1'b1;
    e7z = '0; e7z.vppn = 19'h00777; e7z.asid = 10'd9; e7z.ps = 6'd12; e7z.ppn0 = 20'h0F0F0; e7z.v0 = 1'b1;
    e7r = e7z; e7r.e = 1'b1;
    ew = '0;  ew.vppn = 19'h0BEEF; ew.ps = 6'd12; ew.asid = 10'd6; ew.e = 1'b1; ew.g = 1'b1;
    ew.ppn0 = 20'h12345; ew.v0 = 1'b1; ew.d0 = 1'b1; ew.mat0 = 2'd1; ew.ppn1 = 20'h54321; ew.v1 = 1'b1; ew.plv1 = 2'd3;

    //          op    ent  idx refill iop asid va            lat sreq we inv wb flush srch ne idx ent
    vecs[0] = '{3'd0, e5,  9, 0, 0, 0, 0,                   2, 1, 0, 0, 1, 0, 1, 0, 5, '0};
    key = e5; key.asid = 10'd4;
    vecs[1] = '{3'd0, key, 9, 0, 0, 0, 0,                   2, 1, 0, 0, 1, 0, 1, 1, 9, '0};
    vecs[2] = '{3'd1, '0,  7, 0, 0, 0, 0,                   2, 0, 0, 0, 1, 0, 0, 1, 7, '0};
    vecs[3] = '{3'd2, ew,  7, 0, 0, 0, 0,                   2, 0, 1, 0, 0, 1, 0, 0, 7, ew};
    vecs[4] = '{3'd1, '0,  7, 0, 0, 0, 0,                   2, 0, 0, 0, 1, 0, 0, 0, 7, ew};
    vecs[5] = '{3'd6, '0,  0, 0, 0, 0, 0,                   1, 0, 0, 0, 0, 0, 0, 0, 0, '0};
    vecs[6] = '{3'd4, '0,  0, 0, 5, 3, 32'h2468A000,        2, 0, 0, 1, 0, 1, 0, 0, 0, '0};
    vecs[7] = '{3'd4, '0,  0, 0, 7, 6, 32'h17DDE000,        2, 0, 0, 1, 0, 1, 0, 0, 0, '0};
    vecs[8] = '{3'd0, e5,  9, 0, 0, 0, 0,                   2, 1, 0, 0, 1, 0, 1, 1, 9, '0};
    vname[0] = "srch_hit";   vname[1] = "srch_asid_miss"; vname[2] = "rd_invalid";
    vname[3] = "wr_idx7";    vname[4] = "rd_valid";       vname[5] = "noop6";
    vname[6] = "inv_op5";    vname[7] = "inv_op7";        vname[8] = "srch_after_inv";

    repeat (3) @(negedge clk);
    pl_clr = 1'b0;
    chk("rst.op_ready", op_ready, 1'b1);
    chk("rst.strobes", {s_req, we, invtlb_valid, csr_wb_valid, done, tlb_flush}, 6'b0);
    chk("rst.data", {csr_wb_entry, csr_wb_index, csr_wb_ne, invtlb_va, invtlb_op, w_index}, '0);
    resetn = 1'b1;

    pl_we = 1'b1; pl_idx = 4'd5; pl_ent = e5;  @(negedge clk);
    pl_idx = 4'd7; pl_ent = e7z; @(negedge clk);
    pl_we = 1'b0; #1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], vname[i]);
    chk("inv_op7.tlb_unchanged", tlb[7], ew);

    // 17 FILLs walk indices 0..15 and wrap; only the last runs in refill context.
    for (int i = 0; i < 17; i++) begin
      fv = '{3'd3, e7z, 4'd2, (i == 16), 0, 0, 0, 2, 0, 1, 0, 0, 1, 0, 0,
             TLBIDLEN'(i % TLBNUM), (i == 16) ? e7r : e7z};
      run_vec(fv, $sformatf("fill%0d", i));
    end
    chk("fill.refill_written_e", tlb[0].e, 1'b1);

    // Request held through a busy RD: second op only accepted the cycle after done.
    begin
      int n, done_n, b_wb, b_we, b_inv, b_done;
      logic rdy1;
      b_wb = n_wb; b_we = n_we; b_inv = n_inv; b_done = n_done;
      csr_index = 4'd7; op_type = 3'd1; op_valid = 1'b1;
      @(negedge clk);
      op_type = 3'd6; rdy1 = op_ready; n = 1; done_n = 0;
      while (!op_ready && n < 12) begin
        if (done) done_n = n;
        @(negedge clk); n++;
      end
      chk("b2b.busy_ready", rdy1, 1'b0);
      chk("b2b.done_cycle", done_n, 2);
      chk("b2b.accept_cycle", n, 3);
      @(negedge clk);
      op_valid = 1'b0;
      chk("b2b.noop_done", done, 1'b1);
      @(negedge clk); #1;
      chk("b2b.counts", {8'(n_done - b_done), 8'(n_wb - b_wb), 8'(n_we - b_we), 8'(n_inv - b_inv)},
          {8'd2, 8'd1, 8'd0, 8'd0});
    end

    // Reset in the WR cycle aborts the write and the completion.
    begin
      int b_done, b_wb;
      csr_entry = ew; csr_index = 4'd3; csr_refill = 1'b0; op_type = 3'd2; op_valid = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
      chk("rstwr.we_seen", we, 1'b1);
      resetn = 1'b0;
      #1;
      chk("rstwr.we_dropped", we, 1'b0);
      b_done = n_done; b_wb = n_wb;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rstwr.op_ready", op_ready, 1'b1);
      chk("rstwr.no_done", n_done - b_done, 0);
      chk("rstwr.no_wb", n_wb - b_wb, 0);
      chk("rstwr.entry_unchanged", tlb[3], e7z);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
